ifetch_prefetch_q: RTL and testbench

//  Parametrised instruction fetch unit with a decoupled prefetch queue. Owns the PC, reads a

---
 rtl/ifetch_prefetch_q.sv | 154 +++++++++++++++
 tb/tb_ifetch_prefetch_q.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_q.sv
// Instruction fetch unit: owns the PC, reads a boot-loadable synchronous instruction RAM
// and buffers fetched words in a small FIFO that feeds decode over valid/ready.
// Redirects and boot entry flush both the queue and any fetch still in flight.
module ifetch_prefetch_q #(
    parameter int unsigned PC_WIDTH       = 8,
    parameter int unsigned I_DATAWIDTH    = 32,
    parameter int unsigned I_ADDRESSWIDTH = 8,
    parameter int unsigned I_SIZE         = 256,
    parameter int unsigned QDEPTH         = 4,
    parameter int unsigned RESET_PC       = 12
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        boot_mode,
    input  logic                        boot_iwe,
    input  logic [I_ADDRESSWIDTH-1:0]   boot_iaddr,
    input  logic [I_DATAWIDTH-1:0]      boot_idata,
    input  logic                        redirect,
    input  logic [PC_WIDTH+1:0]         redirect_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [I_DATAWIDTH-1:0]      instr,
    output logic [PC_WIDTH+1:0]         instr_pc,
    output logic [PC_WIDTH+1:0]         pc_plus4,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BaW  = PC_WIDTH + 2;

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e                  state_q;
    logic [PC_WIDTH-1:0]     pc_q;
    logic                    inflight_q;
    logic [PC_WIDTH-1:0]     inflight_pc_q;
    logic [I_DATAWIDTH-1:0]  rdata_q;
    logic [I_DATAWIDTH-1:0]  ram_q [I_SIZE];

    logic [I_DATAWIDTH-1:0]  q_data_q [QDEPTH];
    logic [BaW-1:0]          q_pc_q   [QDEPTH];
    logic [BaW-1:0]          q_pc4_q  [QDEPTH];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [CntW-1:0]         count_q;

    logic                    run;
    logic                    flush;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [CntW:0]           occupancy;
    logic [BaW-1:0]          push_pc;

    // Byte-offset bits of the redirect target carry no information.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Control decode: in-flight words reserve queue space so the FIFO can never overflow.
    always_comb begin
        run       = (state_q == StRun);
        flush     = run && (boot_mode || redirect);
        occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
        issue     = run && !boot_mode && !redirect && (occupancy < (CntW + 1)'(QDEPTH));
        push      = inflight_q && !flush;
        pop       = instr_valid && instr_ready && !flush;
        push_pc   = {inflight_pc_q, 2'b00};
    end

    // Instruction RAM: boot-time write port, synchronous read for fetch.
    always_ff @(posedge clk) begin
        if (!run && boot_iwe) begin
            ram_q[boot_iaddr] <= boot_idata;
        end
        if (issue) begin
            rdata_q <= ram_q[pc_q[I_ADDRESSWIDTH-1:0]];
        end
    end

    // Mode FSM, PC, in-flight tracking and prefetch queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= boot_mode ? StBoot : StRun;
            pc_q          <= PC_WIDTH'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_data_q[i] <= '0;
                q_pc_q[i]   <= '0;
                q_pc4_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                StBoot: begin
                    pc_q <= PC_WIDTH'(RESET_PC);
                    if (!boot_mode) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (boot_mode) begin
                        state_q <= StBoot;
                        pc_q    <= PC_WIDTH'(RESET_PC);
                    end else if (redirect) begin
                        pc_q <= redirect_pc[BaW-1:2];
                    end else if (issue) begin
                        pc_q <= pc_q + PC_WIDTH'(1);
                    end
                end
                default: state_q <= StBoot;
            endcase

            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    q_data_q[wr_ptr_q] <= rdata_q;
                    q_pc_q[wr_ptr_q]   <= push_pc;
                    q_pc4_q[wr_ptr_q]  <= push_pc + BaW'(4);
                    wr_ptr_q           <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CntW'(1);
                end else if (!push && pop) begin
                    count_q <= count_q - CntW'(1);
                end
            end
        end
    end

    // Head of queue drives decode directly from registers.
    always_comb begin
        instr_valid = (count_q != '0);
        instr       = q_data_q[rd_ptr_q];
        instr_pc    = q_pc_q[rd_ptr_q];
        pc_plus4    = q_pc4_q[rd_ptr_q];
        q_count     = count_q;
    end

endmodule

// File: tb/tb_ifetch_prefetch_q.sv
// Bench for ifetch_prefetch_q: directed scenarios followed by a random phase, every cycle
// compared against a queue-based model of the fetch/prefetch rules.
module tb_ifetch_prefetch_q;

    logic        clk = 1'b0;
    logic        resetn;
    logic        boot_mode;
    logic        boot_iwe;
    logic [7:0]  boot_iaddr;
    logic [31:0] boot_idata;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic [9:0]  pc_plus4;
    logic [2:0]  q_count;

    ifetch_prefetch_q dut (
        .clk         (clk),
        .resetn      (resetn),
        .boot_mode   (boot_mode),
        .boot_iwe    (boot_iwe),
        .boot_iaddr  (boot_iaddr),
        .boot_idata  (boot_idata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode flag, word PC, queue of byte addresses, pending fetches, RAM image.
    int          m_boot;
    int          m_pc;
    int          mq[$];
    int          mp[$];
    logic [31:0] mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = boot_mode ? 1 : 0;
        m_pc   = 12;
        mq.delete();
        mp.delete();
    endtask

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        int occ;
        if (m_boot != 0) begin
            if (boot_iwe) mem[boot_iaddr] = boot_idata;
            if (!boot_mode) m_boot = 0;
            m_pc = 12;
            mq.delete();
            mp.delete();
        end else if (boot_mode) begin
            m_boot = 1;
            m_pc   = 12;
            mq.delete();
            mp.delete();
        end else if (redirect) begin
            m_pc = int'(redirect_pc) / 4;
            mq.delete();
            mp.delete();
        end else begin
            occ = mq.size() + mp.size();
            if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
            while (mp.size() > 0) mq.push_back(mp.pop_front());
            if (occ < 4) begin
                mp.push_back(m_pc * 4);
                m_pc = (m_pc + 1) % 256;
            end
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(instr_valid), 32'(mq.size() > 0));
        chk("q_count", 32'(q_count), 32'(mq.size()));
        if (mq.size() > 0) begin
            chk("instr_pc", 32'(instr_pc), 32'(mq[0]));
            chk("pc_plus4", 32'(pc_plus4), 32'((mq[0] + 4) % 1024));
            chk("instr", instr, mem[mq[0] / 4]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_count"}, 32'(q_count), 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_pc"}, 32'(instr_pc), 32'd0);
        chk({tag, "_plus4"}, 32'(pc_plus4), 32'd0);
    endtask

    initial begin
        int          got[$];
        int          bootcnt;
        logic [31:0] w20;

        resetn      = 1'b0;
        boot_mode   = 1'b1;
        boot_iwe    = 1'b0;
        boot_iaddr  = '0;
        boot_idata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        #12;
        chk_zero_outputs("reset");
        model_reset();
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // 1: boot-load RAM, exit boot, expect A0..A3 one per cycle.
        boot_iwe = 1'b1;
        for (int i = 0; i < 256; i++) begin
            boot_iaddr = 8'(i);
            boot_idata = (i >= 12 && i <= 15) ? 32'hA0A0_0000 + 32'(i - 12) : $urandom;
            tick();
        end
        boot_iwe    = 1'b0;
        boot_mode   = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk("t1_exit_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("t1_issue_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("t1_first_pc", 32'(instr_pc), 32'h30);
        chk("t1_first_instr", instr, 32'hA0A0_0000);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_seq_pc", 32'(instr_pc), 32'h30 + 32'(4 * i));
            chk("t1_seq_instr", instr, 32'hA0A0_0000 + 32'(i));
        end

        // 2: decode stalled, queue saturates, then drains in order.
        boot_mode = 1'b1;
        tick();
        boot_mode   = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t2_full", 32'(q_count), 32'd4);
        chk("t2_head", 32'(instr_pc), 32'h30);
        instr_ready = 1'b1;
        for (int k = 0; k < 20 && got.size() < 5; k++) begin
            if (instr_valid) got.push_back(int'(instr_pc));
            tick();
        end
        chk("t2_drained", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size(); i++) chk("t2_order", 32'(got[i]), 32'h30 + 32'(4 * i));

        // 3: redirect with words queued and one in flight.
        boot_mode = 1'b1;
        tick();
        boot_mode   = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        redirect    = 1'b1;
        redirect_pc = 10'h080;
        tick();
        redirect = 1'b0;
        chk("t3_flushed", 32'(q_count), 32'd0);
        tick();
        chk("t3_gap", 32'(instr_valid), 32'd0);
        tick();
        chk("t3_target", 32'(instr_pc), 32'h80);
        for (int i = 0; i < 4; i++) tick();

        // 4: redirect coinciding with a pop, then back-to-back redirects.
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        redirect    = 1'b1;
        redirect_pc = 10'h040;
        tick();
        redirect_pc = 10'h061;
        tick();
        redirect = 1'b0;
        tick();
        chk("t4_gap", 32'(instr_valid), 32'd0);
        tick();
        chk("t4_last_wins", 32'(instr_pc), 32'h60);

        // 5: PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 10'h3FC;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk("t5_top_pc", 32'(instr_pc), 32'h3FC);
        chk("t5_top_plus4", 32'(pc_plus4), 32'h000);
        tick();
        chk("t5_wrap_pc", 32'(instr_pc), 32'h000);

        // 6: RUN-mode writes ignored, boot entry mid-stream, async reset mid-fetch.
        w20        = mem[20];
        boot_iwe   = 1'b1;
        boot_iaddr = 8'd20;
        boot_idata = ~w20;
        tick();
        tick();
        boot_iwe    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 10'h050;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk("t6_ram_kept", instr, w20);
        boot_mode = 1'b1;
        tick();
        chk("t6_boot_valid", 32'(instr_valid), 32'd0);
        boot_mode = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk_zero_outputs("t6_async");
        model_reset();
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Random phase.
        bootcnt = 0;
        for (int c = 0; c < 600; c++) begin
            instr_ready = ($urandom % 4) != 0;
            redirect    = ($urandom % 16) == 0;
            redirect_pc = 10'($urandom);
            boot_iwe    = 1'($urandom);
            boot_iaddr  = 8'($urandom);
            boot_idata  = $urandom;
            if (bootcnt > 0) begin
                boot_mode = 1'b1;
                bootcnt--;
            end else begin
                boot_mode = 1'b0;
                if (($urandom % 64) == 0) bootcnt = 1 + int'($urandom % 3);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
